// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants and width helpers for the servo PWM generator
package servo_pkg;

  localparam int CODE_W = 8;

  function automatic int us_cnt_width(input int frame_us);
    return $clog2(frame_us);
  endfunction

  // Pulse width in microseconds; span_us is a parameter, so the product is a constant multiply.
  function automatic logic [31:0] width_us(input logic [CODE_W-1:0] pos,
                                           input int unsigned min_us,
                                           input int unsigned span_us);
    return min_us + ((32'(pos) * span_us) >> 8);
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// rtl/us_tick_gen.sv - one-cycle tick every DIV clocks (microsecond timebase)
module us_tick_gen #(
  parameter int DIV = 50
) (
  input  logic clk_clk,
  input  logic reset_reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - hobby-servo pulse train from an 8-bit position code, with per-frame slew limit
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int FRAME_US  = 20000,
  parameter int MIN_US    = 1000,
  parameter int SPAN_US   = 1000,
  parameter int SLEW_STEP = 4,
  parameter int RESET_POS = 128
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [CODE_W-1:0] pwm_control_export,
  input  logic              enable,
  output logic              servo_pwm,
  output logic              frame_tick,
  output logic [CODE_W-1:0] position,
  output logic              busy
);

  localparam int DIV   = CLK_HZ / 1000000;
  localparam int CNT_W = us_cnt_width(FRAME_US);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FRAME_US - 1);
  localparam logic [CODE_W-1:0] POS_RST = CODE_W'(RESET_POS);
  localparam logic [CODE_W-1:0] STEP    = CODE_W'(SLEW_STEP);

  if (MIN_US + SPAN_US >= FRAME_US) begin : g_bad_width
    $fatal(1, "servo_pwm_gen: MIN_US + SPAN_US must be below FRAME_US");
  end
  if (CLK_HZ % 1000000 != 0) begin : g_bad_clk
    $fatal(1, "servo_pwm_gen: CLK_HZ must be a multiple of 1 MHz");
  end
  if (SLEW_STEP >= 256) begin : g_bad_slew
    $fatal(1, "servo_pwm_gen: SLEW_STEP must be below 256");
  end

  logic                 us_tick;
  logic                 frame_end;
  logic [CNT_W-1:0]     us_cnt;
  logic [CODE_W-1:0]    target;
  logic [CODE_W-1:0]    target_next;
  logic [CODE_W-1:0]    position_next;
  logic signed [CODE_W:0] diff;
  logic [CODE_W:0]      mag;
  logic [31:0]          width;

  us_tick_gen #(.DIV(DIV)) u_us_tick (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .tick        (us_tick)
  );

  assign frame_end = us_tick && (us_cnt == CNT_MAX);
  assign width     = width_us(position, MIN_US, SPAN_US);

  // The step toward the target only happens when |diff| > STEP, so position cannot wrap.
  always_comb begin
    diff          = $signed({1'b0, pwm_control_export}) - $signed({1'b0, position});
    mag           = diff[CODE_W] ? CODE_W'(0) - diff : diff;
    target_next   = target;
    position_next = position;
    if (frame_end) begin
      target_next = pwm_control_export;
      if (SLEW_STEP == 0 || mag <= {1'b0, STEP}) begin
        position_next = pwm_control_export;
      end else if (diff[CODE_W]) begin
        position_next = position - STEP;
      end else begin
        position_next = position + STEP;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      us_cnt <= '0;
    end else if (us_tick) begin
      us_cnt <= frame_end ? '0 : us_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      target     <= POS_RST;
      position   <= POS_RST;
      busy       <= 1'b0;
      frame_tick <= 1'b0;
      servo_pwm  <= 1'b0;
    end else begin
      target     <= target_next;
      position   <= position_next;
      busy       <= (position_next != target_next);
      frame_tick <= frame_end;
      servo_pwm  <= enable && (32'(us_cnt) < width);
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb/tb_servo_pwm_gen.sv - directed scoreboard bench for servo_pwm_gen (1 MHz clock, 3000 us frame)
module tb_servo_pwm_gen;

  localparam int FRAME = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] code0, code4;
  logic       pwm0, ft0, busy0;
  logic       pwm4, ft4, busy4;
  logic [7:0] pos0, pos4;

  int n_vec = 0;
  int n_err = 0;
  int exp_w[$];
  logic [8:0] exp_p4[$];

  always #5 clk = ~clk;

  servo_pwm_gen #(.CLK_HZ(1000000), .FRAME_US(FRAME), .MIN_US(1000), .SPAN_US(1000),
                  .SLEW_STEP(0), .RESET_POS(128)) dut0 (
    .clk_clk(clk), .reset_reset(rst), .pwm_control_export(code0), .enable(en),
    .servo_pwm(pwm0), .frame_tick(ft0), .position(pos0), .busy(busy0));

  servo_pwm_gen #(.CLK_HZ(1000000), .FRAME_US(FRAME), .MIN_US(1000), .SPAN_US(1000),
                  .SLEW_STEP(4), .RESET_POS(128)) dut4 (
    .clk_clk(clk), .reset_reset(rst), .pwm_control_export(code4), .enable(en),
    .servo_pwm(pwm4), .frame_tick(ft4), .position(pos4), .busy(busy4));

  task automatic check(input string tag, input string sub, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=%0d expected=%0d", tag, sub, obs, exp);
    end
  endtask

  task automatic check_slew(input string tag);
    logic [8:0] e;
    if (exp_p4.size() == 0) begin
      check(tag, "slew_queue_empty", 1, 0);
    end else begin
      e = exp_p4.pop_front();
      check(tag, "pos4", {24'd0, pos4}, {24'd0, e[8:1]});
      check(tag, "busy4", {31'd0, busy4}, {31'd0, e[0]});
    end
  endtask

  // Starts at a negedge with us_cnt == 0; returns at the next frame's us_cnt == 0 negedge.
  task automatic run_frame(input string tag, input bit tick0, input int code_at,
                           input logic [7:0] code_val, input int en_off, input int en_on,
                           input int rst_at);
    int highs = 0;
    int stray = 0;
    int w;
    for (int i = 0; i < FRAME; i++) begin
      if (i == 0) begin
        check(tag, "tick0", {31'd0, ft0}, {31'd0, tick0});
        check(tag, "tick4", {31'd0, ft4}, {31'd0, tick0});
      end else if (ft0 !== 1'b0 || ft4 !== 1'b0) begin
        stray++;
      end
      if (pwm0 === 1'b1) highs++;
      if (en_off >= 0 && i == en_off + 1) check(tag, "pwm_after_disable", {31'd0, pwm0}, 0);
      if (en_on >= 0 && i == en_on + 1) check(tag, "pwm_after_enable", {31'd0, pwm0}, 1);
      if (i == code_at) code0 = code_val;
      if (i == en_off) en = 1'b0;
      if (i == en_on) en = 1'b1;
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check(tag, "rst_pwm", {31'd0, pwm0}, 0);
        check(tag, "rst_tick", {31'd0, ft0}, 0);
        check(tag, "rst_pos0", {24'd0, pos0}, 128);
        check(tag, "rst_busy0", {31'd0, busy0}, 0);
        check(tag, "rst_pos4", {24'd0, pos4}, 128);
        break;
      end
      @(negedge clk);
    end
    w = (exp_w.size() != 0) ? exp_w.pop_front() : -1;
    check(tag, "high_cycles", highs, w);
    check(tag, "stray_ticks", stray, 0);
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    code0 = 8'd128;
    code4 = 8'd128;
    repeat (3) @(negedge clk);
    check("reset", "pwm", {31'd0, pwm0}, 0);
    check("reset", "tick", {31'd0, ft0}, 0);
    check("reset", "pos0", {24'd0, pos0}, 128);
    check("reset", "busy0", {31'd0, busy0}, 0);
    check("reset", "pos4", {24'd0, pos4}, 128);
    rst = 1'b0;

    code4 = 8'd140;
    exp_p4.push_back({8'd132, 1'b1});
    exp_p4.push_back({8'd136, 1'b1});
    exp_p4.push_back({8'd140, 1'b0});
    exp_w.push_back(1500);
    run_frame("f0_code128", 1'b0, -1, 8'd0, -1, -1, -1);

    check("f1", "pos0", {24'd0, pos0}, 128);
    check("f1", "busy0", {31'd0, busy0}, 0);
    check_slew("f1");
    code0 = 8'd0;
    exp_w.push_back(1500);
    run_frame("f1_code128", 1'b1, -1, 8'd0, -1, -1, -1);

    check("f2", "pos0", {24'd0, pos0}, 0);
    check("f2", "busy0", {31'd0, busy0}, 0);
    check_slew("f2");
    code0 = 8'd255;
    exp_w.push_back(1000);
    run_frame("f2_code0", 1'b1, -1, 8'd0, -1, -1, -1);

    check("f3", "pos0", {24'd0, pos0}, 255);
    check_slew("f3");
    code4 = 8'd100;
    exp_p4.push_back({8'd136, 1'b1});
    code0 = 8'd128;
    exp_w.push_back(1996);
    run_frame("f3_code255", 1'b1, -1, 8'd0, -1, -1, -1);

    check_slew("f4");
    exp_w.push_back(1500);
    run_frame("f4_midframe", 1'b1, 700, 8'd200, -1, -1, -1);

    check("f5", "pos0", {24'd0, pos0}, 200);
    code0 = 8'd128;
    exp_w.push_back(1781);
    run_frame("f5_code200", 1'b1, -1, 8'd0, -1, -1, -1);

    exp_w.push_back(800);
    run_frame("f6_enable", 1'b1, -1, 8'd0, 500, 1200, -1);

    code0 = 8'd200;
    exp_w.push_back(1500);
    run_frame("f7", 1'b1, -1, 8'd0, -1, -1, -1);

    check("f8", "pos0", {24'd0, pos0}, 200);
    code0 = 8'd128;
    exp_w.push_back(1781);
    run_frame("f8_reset", 1'b1, -1, 8'd0, -1, -1, 2000);

    exp_w.push_back(1500);
    run_frame("f9_after_reset", 1'b0, -1, 8'd0, -1, -1, -1);
    exp_w.push_back(1500);
    run_frame("f10", 1'b1, -1, 8'd0, -1, -1, -1);

    check("end", "scoreboard_left", exp_w.size() + exp_p4.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
